// File: rtl/cpu_defs.sv
// Shared CPU definitions: arbiter FSM state encoding and default bus widths.
// No ports; imported by mem_arbiter and arb_starve_counter.
package cpu_defs;

   localparam int unsigned ADDR_W_DEF     = 16;
   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned STARVE_MAX_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_DM_BUSY = 2'd2
   } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants issued while a fetch is waiting; saturates at MAX.
// Ports: clock, reset (sync active-low), if_req, if_grant, dm_grant in;
//        at_max_c out (combinational: counter has reached MAX).
module arb_starve_counter
   import cpu_defs::*;
#(
   parameter int unsigned MAX = STARVE_MAX_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic if_req,
   input  logic if_grant,
   input  logic dm_grant,
   output logic at_max_c
);

   localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [CNT_W-1:0] count;

   assign at_max_c = (count == CNT_W'(MAX));

   // A fetch grant or an absent fetch resets the run of data grants.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (!if_req || if_grant) begin
         count <= '0;
      end else if (dm_grant && !at_max_c) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch (if_*) and data
// memory (dm_*) requesters, data first with a starvation guard for fetch.
// Ports: clock, reset (sync active-low); if_req/if_addr/if_abort in,
//        if_ready/if_rdata/if_stall out; dm_req/dm_we/dm_addr/dm_wdata/dm_be in,
//        dm_ready/dm_rdata/dm_stall out; mem_req/mem_we/mem_addr/mem_wdata/mem_be
//        out (registered), mem_ready/mem_rdata in.
module mem_arbiter
   import cpu_defs::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_abort,
   output logic                if_ready,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic                dm_ready,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                if_stall,
   output logic                dm_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_e state;
   arb_state_e state_next;
   logic       grant_if;
   logic       grant_dm;
   logic       cand_if;
   logic       cand_dm;
   logic       arb_en;
   logic       starve_max;
   logic       drop;

   arb_starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req),
      .if_grant (grant_if),
      .dm_grant (grant_dm),
      .at_max_c (starve_max)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state and grant: arbitrate in IDLE, or on completion excluding the finisher.
   always_comb begin
      state_next = state;
      arb_en     = 1'b0;
      cand_if    = 1'b0;
      cand_dm    = 1'b0;
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      case (state)
         ST_IDLE: begin
            arb_en  = 1'b1;
            cand_if = if_req & ~if_abort;
            cand_dm = dm_req;
         end
         ST_IF_BUSY: begin
            arb_en  = mem_ready;
            cand_dm = dm_req;
         end
         ST_DM_BUSY: begin
            arb_en  = mem_ready;
            cand_if = if_req & ~if_abort;
         end
         default: state_next = ST_IDLE;
      endcase
      if (arb_en) begin
         grant_dm = cand_dm & ~(cand_if & starve_max);
         grant_if = cand_if & ~grant_dm;
         if (grant_dm)      state_next = ST_DM_BUSY;
         else if (grant_if) state_next = ST_IF_BUSY;
         else               state_next = ST_IDLE;
      end
   end

   // Completion outputs; a dropped fetch finishes on the bus silently.
   always_comb begin
      if_ready = 1'b0;
      dm_ready = 1'b0;
      if_rdata = '0;
      dm_rdata = '0;
      if (reset && mem_ready) begin
         case (state)
            ST_IF_BUSY: begin
               if (!drop && !if_abort) begin
                  if_ready = 1'b1;
                  if_rdata = mem_rdata;
               end
            end
            ST_DM_BUSY: begin
               dm_ready = 1'b1;
               dm_rdata = mem_rdata;
            end
            default: ;
         endcase
      end
      if_stall = if_req & ~if_ready;
      dm_stall = dm_req & ~dm_ready;
   end

   // Drop flag: remembers a redirect seen while the fetch is still on the bus.
   always_ff @(posedge clock) begin
      if (!reset) begin
         drop <= 1'b0;
      end else if (state == ST_IF_BUSY) begin
         if (mem_ready)     drop <= 1'b0;
         else if (if_abort) drop <= 1'b1;
      end else begin
         drop <= 1'b0;
      end
   end

   // Memory-side request, captured at grant and held for the whole access.
   always_ff @(posedge clock) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else if (grant_dm) begin
         mem_req   <= 1'b1;
         mem_we    <= dm_we;
         mem_addr  <= dm_addr;
         mem_wdata <= dm_wdata;
         mem_be    <= dm_be;
      end else if (grant_if) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
         mem_be    <= BE_W'(0);
      end else if (state != ST_IDLE && mem_ready) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end
   end

endmodule
